// File: rtl/tensor_pkg.sv
// Shared types, tile geometry and lane mapping for the tensor operand path.
// Used by tensor_operand_packer, tensor_operand_slot and the bench model.
package tensor_pkg;

  localparam int TENSOR_LANES = 8;
  localparam int TILE_M       = 4;
  localparam int TILE_N       = 4;
  localparam int TILE_K       = 2;

  typedef enum logic [1:0] {
    KIND_A  = 2'd0,
    KIND_B  = 2'd1,
    KIND_C0 = 2'd2,
    KIND_C1 = 2'd3
  } kind_e;

  function automatic logic [2:0] a_lane(input int r, input int c);
    return 3'(2 * r + c);
  endfunction

  function automatic logic [2:0] b_lane(input int r, input int c);
    return 3'(4 * r + c);
  endfunction

  // C rows 0-1 come from C0, rows 2-3 from C1; both use the same lanes
  function automatic logic [2:0] c_lane(input int r, input int c);
    return 3'(4 * (r % 2) + c);
  endfunction

endpackage

// File: rtl/tensor_operand_slot.sv
// Single registered output slot with valid/ready handshake.
// A load in the same cycle as a drain keeps the slot full with new data.
module tensor_operand_slot
  import tensor_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/tensor_operand_packer.sv
// Collects A/B/C0/C1 operand beats into a tile set for the dot-product unit.
// Define TENSOR_OPERAND_PACKER_PERF_EN to add perf_issued/perf_stall counters.
`ifndef NW_WIDTH
`define NW_WIDTH 4
`endif

module tensor_operand_packer
  import tensor_pkg::*;
#(
  parameter int WIDW       = `NW_WIDTH,
  parameter int PERF_CTR_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   beat_valid,
  output logic                   beat_ready,
  input  logic [1:0]             beat_kind,
  input  logic [WIDW-1:0]        beat_wid,
  input  logic [7:0][31:0]       beat_data,
  output logic                   valid_out,
  input  logic                   ready_out,
  output logic [3:0][1:0][31:0]  A_tile,
  output logic [1:0][3:0][31:0]  B_tile,
  output logic [3:0][3:0][31:0]  C_tile,
  output logic [WIDW-1:0]        wid_out,
`ifdef TENSOR_OPERAND_PACKER_PERF_EN
  output logic [PERF_CTR_W-1:0]  perf_issued,
  output logic [PERF_CTR_W-1:0]  perf_stall,
`endif
  output logic                   protocol_err
);

  localparam int DW = 256 + 256 + 512 + WIDW;

  kind_e state_q, state_d;

  logic [3:0][1:0][31:0] a_q;
  logic [1:0][3:0][31:0] b_q;
  logic [1:0][3:0][31:0] c0_q;
  logic [WIDW-1:0]       wid_q;
  logic                  err_q;

  logic [3:0][1:0][31:0] a_in;
  logic [1:0][3:0][31:0] b_in;
  logic [1:0][3:0][31:0] c_in;

  logic          accept, good, bad, load;
  logic [DW-1:0] slot_d, slot_q;

  always_comb begin
    a_in = '0;
    b_in = '0;
    c_in = '0;
    for (int r = 0; r < TILE_M; r++)
      for (int c = 0; c < TILE_K; c++)
        a_in[r][c] = beat_data[a_lane(r, c)];
    for (int r = 0; r < TILE_K; r++)
      for (int c = 0; c < TILE_N; c++) begin
        b_in[r][c] = beat_data[b_lane(r, c)];
        c_in[r][c] = beat_data[c_lane(r, c)];
      end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= KIND_A;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = KIND_A;
    end else if (good) begin
      unique case (state_q)
        KIND_A:  state_d = KIND_B;
        KIND_B:  state_d = KIND_C0;
        KIND_C0: state_d = KIND_C1;
        KIND_C1: state_d = KIND_A;
      endcase
    end
  end

  // Only C1 can stall: it is the beat that needs the output slot
  always_comb begin
    beat_ready = !flush &&
      ((state_q != KIND_C1) || !valid_out || ready_out);
    accept = beat_valid && beat_ready;
    good   = accept && (beat_kind == state_q) &&
      ((state_q == KIND_A) || (beat_wid == wid_q));
    bad    = accept && !good;
    load   = good && (state_q == KIND_C1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      c0_q  <= '0;
      wid_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= bad;
      if (good) begin
        unique case (state_q)
          KIND_A: begin
            a_q   <= a_in;
            wid_q <= beat_wid;
          end
          KIND_B:  b_q  <= b_in;
          KIND_C0: c0_q <= c_in;
          KIND_C1: begin
          end
        endcase
      end
    end
  end

  assign slot_d = {a_q, b_q, c_in, c0_q, wid_q};

  tensor_operand_slot #(
    .DW(DW)
  ) u_slot (
    .clk    (clk),
    .rst    (reset),
    .load_i (load),
    .data_i (slot_d),
    .ready_i(ready_out),
    .valid_o(valid_out),
    .data_o (slot_q)
  );

  assign {A_tile, B_tile, C_tile, wid_out} = slot_q;
  assign protocol_err = err_q;

`ifdef TENSOR_OPERAND_PACKER_PERF_EN
  logic [PERF_CTR_W-1:0] issued_q, stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (valid_out && ready_out)  issued_q <= issued_q + 1'b1;
      if (beat_valid && !beat_ready) stall_q <= stall_q + 1'b1;
    end
  end

  assign perf_issued = issued_q;
  assign perf_stall  = stall_q;
`endif

endmodule
